life_grid_engine: RTL and testbench

//  Parametrised Conway Life engine: ROWS x COLS cell grid, B3/S23 rule, all cells updated in one clock per generation.

---
 rtl/life_grid_engine.sv | 211 +++++++++++++++++++++
 tb/tb_life_grid_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_grid_engine.sv
// Conway Life engine (B3/S23): whole ROWS x COLS grid advances in one clock per generation.
// Supports single-step and free-run with a programmable period, toroidal or dead edges,
// stable/extinct detection with optional auto-halt, and a registered row read port.
module life_grid_engine #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int GEN_W     = 16,
  parameter bit AUTO_HALT = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [$clog2(ROWS)-1:0] wr_row_i,
  input  logic [COLS-1:0]         wr_data_i,
  input  logic [$clog2(ROWS)-1:0] rd_row_i,
  output logic [COLS-1:0]         rd_data_o,
  input  logic                    wrap_i,
  input  logic                    step_i,
  input  logic                    run_i,
  input  logic [15:0]             period_i,
  output logic                    gen_pulse_o,
  output logic [GEN_W-1:0]        generation_o,
  output logic                    stable_o,
  output logic                    extinct_o,
  output logic                    halted_o
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic             pend_q, pend_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stable_q, stable_d;
  logic             extinct_q, extinct_d;
  logic             pulse_q;
  logic [COLS-1:0]  rd_q, rd_d;
  logic [COLS-1:0]  grid_q [ROWS];
  logic [COLS-1:0]  grid_d [ROWS];
  logic [COLS-1:0]  next_grid [ROWS];
  logic [COLS-1:0]  wr_grid [ROWS];
  logic             next_same, next_zero, wr_zero;
  logic             wr_valid, due, advance;

  // Next generation of every cell from its eight neighbours.
  always_comb begin
    int rr;
    int cc;
    logic [3:0] cnt;
    logic nb;
    rr        = 0;
    cc        = 0;
    cnt       = '0;
    nb        = 1'b0;
    next_same = 1'b1;
    next_zero = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      next_grid[r] = '0;
      for (int c = 0; c < COLS; c++) begin
        cnt = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              nb = 1'b0;
              if (wrap_i) begin
                if (rr < 0) rr = rr + ROWS;
                else if (rr >= ROWS) rr = rr - ROWS;
                if (cc < 0) cc = cc + COLS;
                else if (cc >= COLS) cc = cc - COLS;
                nb = grid_q[rr[RW-1:0]][cc[CW-1:0]];
              end else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                nb = grid_q[rr[RW-1:0]][cc[CW-1:0]];
              end
              cnt = cnt + {3'b000, nb};
            end
          end
        end
        next_grid[r][c] = (cnt == 4'd3) | (grid_q[r][c] & (cnt == 4'd2));
      end
      next_same = next_same & (next_grid[r] == grid_q[r]);
      next_zero = next_zero & (next_grid[r] == '0);
    end
  end

  // Row write overlay, read mux, and write validity.
  always_comb begin
    wr_valid = wr_en_i && (int'(wr_row_i) < ROWS);
    wr_zero  = 1'b1;
    rd_d     = '0;
    for (int r = 0; r < ROWS; r++) begin
      wr_grid[r] = (wr_row_i == RW'(r)) ? wr_data_i : grid_q[r];
      wr_zero    = wr_zero & (wr_grid[r] == '0);
      if (rd_row_i == RW'(r)) rd_d = grid_q[r];
    end
  end

  // Sequencing: decide when an advance is due, handle write collisions and halting.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    pend_d  = pend_q;
    due     = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (step_i && !pend_q) due = 1'b1;
        if (run_i) begin
          state_d = StRun;
          pcnt_d  = '0;
        end
      end
      StRun: begin
        if (!run_i) begin
          state_d = StIdle;
          pcnt_d  = '0;
        end else if (pend_q) begin
          // Counter restarts once the deferred advance has gone through.
          pcnt_d = '0;
        end else if (pcnt_q == period_i) begin
          due    = 1'b1;
          pcnt_d = '0;
        end else begin
          pcnt_d = pcnt_q + 16'd1;
        end
      end
      StHalt: begin
        if (!run_i) begin
          state_d = StIdle;
        end else if (wr_valid) begin
          state_d = StRun;
          pcnt_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    // A write always wins; a colliding advance is deferred by one cycle.
    if (wr_valid) begin
      pend_d = pend_q | due;
    end else begin
      advance = due | pend_q;
      pend_d  = 1'b0;
    end
    if (AUTO_HALT && advance && state_d == StRun && (next_same || next_zero)) begin
      state_d = StHalt;
    end
  end

  // Grid and status next-state.
  always_comb begin
    grid_d    = grid_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    if (wr_valid) begin
      grid_d    = wr_grid;
      gen_d     = '0;
      stable_d  = 1'b0;
      extinct_d = wr_zero;
    end else if (advance) begin
      grid_d    = next_grid;
      gen_d     = gen_q + 1'b1;
      stable_d  = next_same;
      extinct_d = next_zero;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      pend_q  <= pend_d;
    end
  end

  // Grid, counters, status flags and read port registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      grid_q    <= '{default: '0};
      gen_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b1;
      pulse_q   <= 1'b0;
      rd_q      <= '0;
    end else begin
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
      pulse_q   <= advance;
      rd_q      <= rd_d;
    end
  end

  assign rd_data_o    = rd_q;
  assign gen_pulse_o  = pulse_q;
  assign generation_o = gen_q;
  assign stable_o     = stable_q;
  assign extinct_o    = extinct_q;
  assign halted_o     = (state_q == StHalt);

endmodule

// File: tb/tb_life_grid_engine.sv
// Scoreboard bench for life_grid_engine: one instance without auto-halt, one with.
module tb_life_grid_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_row = '0;
  logic [7:0]  wr_data = '0;
  logic [2:0]  rd_row = '0;
  logic        wrap = 1'b0;
  logic        step = 1'b0;
  logic        run = 1'b0;
  logic [15:0] period = '0;

  logic [7:0]  rd0, rdh;
  logic        p0, ph, s0, sh, e0, eh, h0, hh;
  logic [15:0] g0, gh;

  always #5 clk = ~clk;

  life_grid_engine #(.ROWS(8), .COLS(8), .GEN_W(16), .AUTO_HALT(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_row_i(wr_row), .wr_data_i(wr_data),
    .rd_row_i(rd_row), .rd_data_o(rd0), .wrap_i(wrap), .step_i(step), .run_i(run),
    .period_i(period), .gen_pulse_o(p0), .generation_o(g0), .stable_o(s0), .extinct_o(e0),
    .halted_o(h0)
  );

  life_grid_engine #(.ROWS(8), .COLS(8), .GEN_W(16), .AUTO_HALT(1'b1)) u_dut_h (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_row_i(wr_row), .wr_data_i(wr_data),
    .rd_row_i(rd_row), .rd_data_o(rdh), .wrap_i(wrap), .step_i(step), .run_i(run),
    .period_i(period), .gen_pulse_o(ph), .generation_o(gh), .stable_o(sh), .extinct_o(eh),
    .halted_o(hh)
  );

  typedef struct {
    logic [15:0] gen;
    logic [63:0] grid;
    logic        stable;
    logic        extinct;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] mgrid = '0;
  int          mgen = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference B3/S23 step on an 8x8 grid, bit r*8+c = cell (r,c).
  function automatic logic [63:0] life_next(input logic [63:0] g, input bit wr);
    logic [63:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              if (wr) begin
                rr = (rr + 8) % 8;
                cc = (cc + 8) % 8;
                cnt += int'(g[rr*8+cc]);
              end else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                cnt += int'(g[rr*8+cc]);
              end
            end
          end
        end
        n[r*8+c] = (cnt == 3) || (g[r*8+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  task automatic read_grid(input bit from_h, output logic [63:0] g);
    g = '0;
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      @(negedge clk);
      g[r*8+:8] = from_h ? rdh : rd0;
    end
  endtask

  task automatic push_adv();
    exp_t e;
    logic [63:0] nx;
    nx = life_next(mgrid, wrap);
    e.stable  = (nx == mgrid);
    e.extinct = (nx == '0);
    mgrid = nx;
    mgen++;
    e.gen  = 16'(mgen);
    e.grid = nx;
    sb_q.push_back(e);
  endtask

  task automatic wait_pulse();
    int k;
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      if (p0) break;
    end
    if (k == 64) check_val("pulse_timeout", 64'd0, 64'd1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    logic [63:0] g;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    check_val({tag, "_gen"}, 64'(g0), 64'(e.gen));
    check_val({tag, "_stable"}, 64'(s0), 64'(e.stable));
    check_val({tag, "_extinct"}, 64'(e0), 64'(e.extinct));
    read_grid(1'b0, g);
    check_val({tag, "_grid"}, g, e.grid);
  endtask

  task automatic write_row(input int r, input logic [7:0] d);
    wr_row  = 3'(r);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    mgrid[r*8+:8] = d;
    mgen = 0;
  endtask

  task automatic do_step(input string tag);
    push_adv();
    step = 1'b1;
    wait_pulse();
    step = 1'b0;
    pop_check(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    wr_en = 1'b0;
    step  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mgrid = '0;
    mgen  = 0;
    sb_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] g, init, nx, gp;
    bit seen;
    int k, n, gb;

    // Reset with run and write asserted.
    rst_n = 1'b0; run = 1'b1; wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hFF;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (p0 || ph) seen = 1'b1;
    end
    check_val("rst_gen", 64'(g0), 64'd0);
    check_val("rst_extinct", 64'(e0), 64'd1);
    check_val("rst_halted", 64'({h0, hh}), 64'd0);
    check_val("rst_stable", 64'(s0), 64'd0);
    check_val("rst_pulse", 64'(seen), 64'd0);
    check_val("rst_rd", 64'(rd0), 64'd0);
    run = 1'b0; wr_en = 1'b0; rst_n = 1'b1;
    read_grid(1'b0, g);
    check_val("rst_grid", g, 64'd0);

    // Blinker, dead edges.
    wrap = 1'b0;
    write_row(3, 8'h1C);
    check_val("blk_wr_extinct", 64'(e0), 64'd0);
    check_val("blk_wr_gen", 64'(g0), 64'd0);
    do_step("blk1");
    read_grid(1'b0, g);
    check_val("blk_vert", g, 64'h0000_0008_0808_0000);
    do_step("blk2");
    read_grid(1'b0, g);
    check_val("blk_horiz", g, 64'h0000_0000_1C00_0000);
    check_val("blk_gen2", 64'(g0), 64'd2);

    // Glider on a torus: period 32 generations, free-run with period 15.
    do_reset();
    wrap = 1'b1;
    write_row(0, 8'h02);
    write_row(1, 8'h04);
    write_row(2, 8'h07);
    init = mgrid;
    period = 16'd15;
    for (int i = 0; i < 32; i++) push_adv();
    run = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_pulse();
      pop_check("glider");
    end
    run = 1'b0;
    read_grid(1'b0, g);
    check_val("glider_return", g, init);
    check_val("glider_gen32", 64'(g0), 64'd32);

    // Glider with dead edges settles; auto-halt instance must stop there.
    do_reset();
    wrap = 1'b0;
    write_row(0, 8'h02);
    write_row(1, 8'h04);
    write_row(2, 8'h07);
    gp = mgrid;
    n = 0;
    nx = gp;
    for (int i = 0; i < 100; i++) begin
      nx = life_next(gp, 1'b0);
      n++;
      if (nx == gp || nx == '0) break;
      gp = nx;
    end
    period = 16'd0;
    run = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (hh) break;
    end
    if (k == 300) check_val("settle_timeout", 64'd0, 64'd1);
    check_val("settle_gen", 64'(gh), 64'(n));
    check_val("settle_stable", 64'(sh), 64'd1);
    check_val("settle_noauto_halted", 64'(h0), 64'd0);
    read_grid(1'b1, g);
    check_val("settle_grid", g, nx);
    run = 1'b0;
    @(negedge clk);
    check_val("halt_to_idle", 64'(hh), 64'd0);

    // Block still life, period 3.
    do_reset();
    write_row(3, 8'h18);
    write_row(4, 8'h18);
    period = 16'd3;
    run = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ph) break;
    end
    check_val("block_latency", 64'(k), 64'd5);
    check_val("block_halted", 64'(hh), 64'd1);
    check_val("block_stable", 64'(sh), 64'd1);
    check_val("block_gen", 64'(gh), 64'd1);
    repeat (6) @(negedge clk);
    check_val("block_halt_hold", 64'(gh), 64'd1);
    write_row(0, 8'h00);
    check_val("halt_wr_resume", 64'(hh), 64'd0);
    check_val("halt_wr_gen", 64'(gh), 64'd0);
    run = 1'b0;
    @(negedge clk);

    // Write colliding with a free-run advance.
    do_reset();
    wrap = 1'b0;
    write_row(3, 8'h1C);
    period = 16'd0;
    run = 1'b1;
    repeat (5) @(negedge clk);
    gb = int'(g0);
    for (int i = 0; i < gb; i++) mgrid = life_next(mgrid, 1'b0);
    mgrid[56+:8] = 8'h81;
    wr_row = 3'd7; wr_data = 8'h81; wr_en = 1'b1; rd_row = 3'd7;
    @(negedge clk);
    wr_en = 1'b0;
    run = 1'b0;
    check_val("coll_gen0", 64'(g0), 64'd0);
    check_val("coll_nopulse", 64'(p0), 64'd0);
    @(negedge clk);
    check_val("coll_gen1", 64'(g0), 64'd1);
    check_val("coll_pulse", 64'(p0), 64'd1);
    check_val("coll_row_kept", 64'(rd0), 64'h81);
    read_grid(1'b0, g);
    check_val("coll_grid", g, life_next(mgrid, 1'b0));
    check_val("coll_no_more", 64'(g0), 64'd1);

    // Single cell dies; read latency and sweep.
    do_reset();
    write_row(5, 8'h10);
    check_val("single_alive", 64'(e0), 64'd0);
    do_step("single");
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      @(negedge clk);
      check_val("sweep_zero", 64'(rd0), 64'd0);
    end
    rd_row = 3'd0;
    @(negedge clk);
    write_row(2, 8'hA5);
    rd_row = 3'd2;
    check_val("rd_latency_old", 64'(rd0), 64'd0);
    @(negedge clk);
    check_val("rd_latency_new", 64'(rd0), 64'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
